// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM state encoding
// and stream-format widths used by the loader top and its word packer.
package imem_loader_pkg;

    localparam int LEN_W  = 16;  // width of the little-endian word-count header
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // States in which the loader consumes stream bytes.
    function automatic logic is_streaming(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: a 2-bit lane counter steers each accepted byte into a
// little-endian pack register and flags the word when its fourth byte arrives.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]  lane;
    logic [23:0] pack;

    // The fourth byte is forwarded directly, so the word is complete in the accept cycle.
    assign word_valid = byte_en && (lane == 2'd3);
    assign word       = {byte_in, pack};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane <= 2'd0;
            pack <= '0;
        end else if (byte_en) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    pack[7:0]   <= byte_in;
                2'd1:    pack[15:8]  <= byte_in;
                2'd2:    pack[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream, writes packed
// words into instruction memory and holds the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W-1:0] DEPTH_W = LEN_W'(DEPTH);

    state_t             state, state_n;
    logic [LEN_W-1:0]   n_len;
    logic [LEN_W-1:0]   index;
    logic [LEN_W-1:0]   hdr_len;
    logic               accept;
    logic               start_ok;
    logic               last_word;
    logic               word_valid;
    logic [WORD_W-1:0]  word;

    assign in_ready  = is_streaming(state);
    assign busy      = is_streaming(state);
    assign accept    = in_valid && in_ready;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign hdr_len   = {in_data, n_len[7:0]};
    assign last_word = (index == n_len - LEN_W'(1));

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .byte_en    (accept && (state == ST_DATA)),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: state_n gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_n = ST_LEN0;
            end
            ST_LEN0: begin
                if (accept) state_n = ST_LEN1;
            end
            ST_LEN1: begin
                if (accept) state_n = (hdr_len == '0) ? ST_DONE : ST_DATA;
            end
            ST_DATA: begin
                if (word_valid && last_word) state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_len   <= '0;
            index   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= BASE_ADDR;
            wr_data <= '0;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= 1'b0;

            if (start_ok) begin
                cpu_rst <= 1'b1;
                done    <= 1'b0;
                err     <= 1'b0;
                index   <= '0;
            end else if (done) begin
                // Release the core one cycle after the image is declared complete.
                cpu_rst <= 1'b0;
            end

            case (state)
                ST_LEN0: begin
                    if (accept) n_len[7:0] <= in_data;
                end
                ST_LEN1: begin
                    if (accept) begin
                        n_len[15:8] <= in_data;
                        index       <= '0;
                        if (hdr_len == '0)    done <= 1'b1;
                        if (hdr_len > DEPTH_W) err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        // Oversized images are drained but never written past the last word.
                        if (index < DEPTH_W) begin
                            wr_en   <= 1'b1;
                            wr_addr <= BASE_ADDR + {{(30 - ADDR_W){1'b0}}, index[ADDR_W-1:0], 2'b00};
                            wr_data <= word;
                        end
                        index <= index + LEN_W'(1);
                        if (last_word) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: a DEPTH=64 and a DEPTH=4 instance share one
// byte stream; writes are logged at the falling edge and compared with hand-computed words.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;

    logic        ready_a, wr_en_a, cpu_rst_a, busy_a, done_a, err_a;
    logic [31:0] wr_addr_a, wr_data_a;
    logic        ready_b, wr_en_b, cpu_rst_b, busy_b, done_b, err_b;
    logic [31:0] wr_addr_b, wr_data_b;

    int checks = 0;
    int errors = 0;
    int bytes_accepted = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        cpu_rst;
    } wr_rec_t;

    wr_rec_t q_a[$];
    wr_rec_t q_b[$];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(64), .ADDR_W(6), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .cpu_rst(cpu_rst_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    imem_loader #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(32'h0000_0000)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .cpu_rst(cpu_rst_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    always @(negedge clk) begin
        if (wr_en_a) q_a.push_back('{wr_addr_a, wr_data_a, done_a, cpu_rst_a});
        if (wr_en_b) q_b.push_back('{wr_addr_b, wr_data_b, done_b, cpu_rst_b});
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int tries = 0;
        forever begin
            @(negedge clk);
            tries++;
            if (tries > 60) begin
                checks++; errors++;
                $display("FAIL send_byte timeout: byte %02h never accepted (in_ready=%b)", b, ready_a);
                in_valid = 1'b0;
                break;
            end
            if (stall && ($urandom_range(1, 0) == 1)) begin
                in_valid = 1'b0;
                continue;
            end
            in_valid = 1'b1;
            in_data  = b;
            if (ready_a) begin
                bytes_accepted++;
                break;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_write(input string name, input wr_rec_t got,
                               input logic [31:0] exp_addr, input logic [31:0] exp_data);
        checks++;
        if (got.addr !== exp_addr || got.data !== exp_data) begin
            errors++;
            $display("FAIL %s: got addr=%08h data=%08h, expected addr=%08h data=%08h",
                     name, got.addr, got.data, exp_addr, exp_data);
        end
    endtask

    task automatic test_reset();
        bit saw_bad = 1'b0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_a.delete(); q_b.delete();
        repeat (10) begin
            @(negedge clk);
            if (cpu_rst_a !== 1'b1 || ready_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0)
                saw_bad = 1'b1;
        end
        checks++;
        if (saw_bad) begin
            errors++;
            $display("FAIL reset_idle: cpu_rst=%b in_ready=%b done=%b busy=%b, expected 1 0 0 0",
                     cpu_rst_a, ready_a, done_a, busy_a);
        end
        checks++;
        if (err_a !== 1'b0 || wr_addr_a !== 32'h0 || wr_data_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: err=%b wr_addr=%08h wr_data=%08h, expected 0 00000000 00000000",
                     err_a, wr_addr_a, wr_data_a);
        end
        checks++;
        if (q_a.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_write: %0d writes, expected 0", q_a.size());
        end
    endtask

    task automatic load_two_words(input bit stall);
        logic [7:0] stream [10];
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        q_a.delete(); q_b.delete();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(stream[i], stall);
    endtask

    task automatic test_basic_load();
        load_two_words(1'b0);
        idle_cycle();
        checks++;
        if (wr_en_a !== 1'b1 || done_a !== 1'b1 || cpu_rst_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_write_cycle: wr_en=%b done=%b cpu_rst=%b, expected 1 1 1",
                     wr_en_a, done_a, cpu_rst_a);
        end
        @(negedge clk);
        checks++;
        if (cpu_rst_a !== 1'b0 || wr_en_a !== 1'b0 || ready_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: cpu_rst=%b wr_en=%b in_ready=%b, expected 0 0 0",
                     cpu_rst_a, wr_en_a, ready_a);
        end
        checks++;
        if (q_a.size() !== 2) begin
            errors++;
            $display("FAIL basic_write_count: %0d writes, expected 2", q_a.size());
        end else begin
            check_write("basic_word0", q_a[0], 32'h0, 32'h0010_0513);
            check_write("basic_word1", q_a[1], 32'h4, 32'h0020_0593);
            checks++;
            if (q_a[0].done !== 1'b0 || q_a[1].done !== 1'b1) begin
                errors++;
                $display("FAIL basic_done_timing: done at writes=%b,%b expected 0,1",
                         q_a[0].done, q_a[1].done);
            end
        end
    endtask

    task automatic test_stalled_load();
        load_two_words(1'b1);
        repeat (4) idle_cycle();
        checks++;
        if (q_a.size() !== 2) begin
            errors++;
            $display("FAIL stall_write_count: %0d writes, expected 2", q_a.size());
        end else begin
            check_write("stall_word0", q_a[0], 32'h0, 32'h0010_0513);
            check_write("stall_word1", q_a[1], 32'h4, 32'h0020_0593);
        end
        checks++;
        if (done_a !== 1'b1 || cpu_rst_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_final: done=%b cpu_rst=%b, expected 1 0", done_a, cpu_rst_a);
        end
    endtask

    task automatic test_zero_length();
        bit seen = 1'b0;
        q_a.delete(); q_b.delete();
        pulse_start();
        checks++;
        if (done_a !== 1'b0 || cpu_rst_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL zero_after_start: done=%b cpu_rst=%b busy=%b, expected 0 1 1",
                     done_a, cpu_rst_a, busy_a);
        end
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            idle_cycle();
            if (done_a === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL zero_done: done=%b within 2 cycles of header, expected 1", done_a);
        end
        repeat (2) idle_cycle();
        checks++;
        if (err_a !== 1'b0 || q_a.size() !== 0 || cpu_rst_a !== 1'b0 || ready_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_final: err=%b writes=%0d cpu_rst=%b in_ready=%b, expected 0 0 0 0",
                     err_a, q_a.size(), cpu_rst_a, ready_a);
        end
    endtask

    task automatic test_overflow();
        q_a.delete(); q_b.delete();
        pulse_start();
        bytes_accepted = 0;
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        idle_cycle();
        checks++;
        if (err_b !== 1'b1 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err: err(depth4)=%b err(depth64)=%b, expected 1 0", err_b, err_a);
        end
        for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
        repeat (2) idle_cycle();
        checks++;
        if (bytes_accepted !== 22 || ready_b !== 1'b0 || done_b !== 1'b1 || err_b !== 1'b1) begin
            errors++;
            $display("FAIL overflow_final: bytes=%0d in_ready=%b done=%b err=%b, expected 22 0 1 1",
                     bytes_accepted, ready_b, done_b, err_b);
        end
        checks++;
        if (q_b.size() !== 4 || q_a.size() !== 5) begin
            errors++;
            $display("FAIL overflow_write_count: depth4=%0d depth64=%0d, expected 4 5",
                     q_b.size(), q_a.size());
        end else begin
            check_write("overflow_w0", q_b[0], 32'h0, 32'h0302_0100);
            check_write("overflow_w1", q_b[1], 32'h4, 32'h0706_0504);
            check_write("overflow_w2", q_b[2], 32'h8, 32'h0B0A_0908);
            check_write("overflow_w3", q_b[3], 32'hC, 32'h0F0E_0D0C);
            check_write("overflow_full_w4", q_a[4], 32'h10, 32'h1312_1110);
        end
    endtask

    task automatic test_reset_mid_load();
        q_a.delete(); q_b.delete();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || cpu_rst_a !== 1'b1 || done_a !== 1'b0 ||
            wr_addr_a !== 32'h0 || wr_data_a !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b cpu_rst=%b done=%b wr_addr=%08h wr_data=%08h, expected 0 1 0 0 0",
                     busy_a, cpu_rst_a, done_a, wr_addr_a, wr_data_a);
        end
        q_a.delete(); q_b.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        checks++;
        if (cpu_rst_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_hold: cpu_rst=%b before final byte, expected 1", cpu_rst_a);
        end
        send_byte(8'h44, 1'b0);
        repeat (3) idle_cycle();
        checks++;
        if (q_a.size() !== 1) begin
            errors++;
            $display("FAIL midreset_write_count: %0d writes, expected 1", q_a.size());
        end else begin
            check_write("midreset_word", q_a[0], 32'h0, 32'h4433_2211);
            checks++;
            if (q_a[0].cpu_rst !== 1'b1) begin
                errors++;
                $display("FAIL midreset_cpu_rst_at_write: cpu_rst=%b, expected 1", q_a[0].cpu_rst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stalled_load();
        test_zero_length();
        test_overflow();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
